sma_edge_capture: RTL and testbench



---
 rtl/sma_edge_capture_pkg.sv | 32 +++
 rtl/sma_edge_capture_if.sv | 19 +
 rtl/sma_evt_fifo.sv | 59 +++++
 rtl/sma_edge_capture.sv | 124 ++++++++++++
 tb/tb_sma_edge_capture.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sma_edge_capture_pkg.sv
// Shared register map, bit positions and CONTROL layout for the SMA edge-capture block.
package sma_pkg;

  typedef enum logic [1:0] {
    ADDR_STATUS  = 2'd0,
    ADDR_CONTROL = 2'd1,
    ADDR_EVENT   = 2'd2,
    ADDR_NOW     = 2'd3
  } sma_addr_e;

  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_RISE_EN = 1;
  localparam int unsigned CTRL_FALL_EN = 2;
  localparam int unsigned CTRL_IRQ_EN  = 3;
  localparam int unsigned CTRL_FLUSH   = 4;

  localparam int unsigned STAT_LVL       = 0;
  localparam int unsigned STAT_NOT_EMPTY = 1;
  localparam int unsigned STAT_OVERFLOW  = 2;
  localparam int unsigned STAT_COUNT_LSB = 4;
  localparam int unsigned STAT_COUNT_MSB = 8;

  localparam int unsigned EVENT_EDGE_BIT = 31;

  typedef struct packed {
    logic irq_en;
    logic fall_en;
    logic rise_en;
    logic enable;
  } sma_ctrl_t;

endpackage

// File: rtl/sma_edge_capture_if.sv
// Avalon-MM register bus between the host and the SMA edge-capture slave.
interface sma_edge_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/sma_evt_fifo.sv
// Synchronous event FIFO; a pop frees a slot for a same-cycle push, and flush beats both.
module sma_evt_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~flush_i & full_o & ~do_pop;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are power-of-two wide, so the increment wraps modulo DEPTH.
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sma_edge_capture.sv
// SMA pin edge timestamper: synchroniser, edge detect, free-running counter,
// register decode with read-to-pop event FIFO, and a level interrupt.
module sma_edge_capture
  import sma_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TS_WIDTH    = 31
) (
  input  logic               clk,
  input  logic               reset_n,
  sma_edge_capture_if.slave  bus,
  input  logic               in_port,
  output logic               irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [TS_WIDTH-1:0]    cnt_q;
  sma_ctrl_t              ctrl_q;
  logic                   ovf_q, ovf_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   irq_q;

  logic        lvl, rise, fall, capture;
  logic        rd_en, wr_en, pop, flush, ovf_clr;
  logic [31:0] evt_word, status_word, now_word;
  logic [31:0] fifo_head;
  logic        fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0] fifo_count;
  logic        unused_wdata;

  assign lvl     = sync_q[SYNC_STAGES-1];
  assign rise    = lvl & ~prev_q;
  assign fall    = ~lvl & prev_q;
  assign capture = ctrl_q.enable & ((rise & ctrl_q.rise_en) | (fall & ctrl_q.fall_en));

  assign rd_en   = bus.chipselect & bus.read;
  assign wr_en   = bus.chipselect & bus.write;
  assign pop     = rd_en & (bus.address == ADDR_EVENT);
  assign flush   = wr_en & (bus.address == ADDR_CONTROL) & bus.writedata[CTRL_FLUSH];
  assign ovf_clr = wr_en & (bus.address == ADDR_STATUS) & bus.writedata[STAT_OVERFLOW];
  assign unused_wdata = ^bus.writedata[31:5];

  always_comb begin
    evt_word = '0;
    evt_word[TS_WIDTH-1:0] = cnt_q;
    evt_word[EVENT_EDGE_BIT] = rise;
  end

  always_comb begin
    now_word = '0;
    now_word[TS_WIDTH-1:0] = cnt_q;
  end

  always_comb begin
    status_word = '0;
    status_word[STAT_LVL]       = lvl;
    status_word[STAT_NOT_EMPTY] = ~fifo_empty;
    status_word[STAT_OVERFLOW]  = ovf_q;
    status_word[STAT_COUNT_MSB:STAT_COUNT_LSB] = 5'(fifo_count);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      unique case (sma_addr_e'(bus.address))
        ADDR_STATUS:  rdata_d = status_word;
        ADDR_CONTROL: rdata_d = {28'd0, ctrl_q};
        ADDR_EVENT:   rdata_d = fifo_empty ? '0 : fifo_head;
        ADDR_NOW:     rdata_d = now_word;
      endcase
    end
  end

  // A drop in the same cycle as a software clear leaves overflow set.
  assign ovf_d = fifo_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q  <= lvl;
      cnt_q   <= cnt_q + TS_WIDTH'(1);
      if (wr_en && (bus.address == ADDR_CONTROL)) ctrl_q <= sma_ctrl_t'(bus.writedata[3:0]);
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
      irq_q   <= ctrl_q.irq_en & (~fifo_empty | ovf_q);
    end
  end

  sma_evt_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (capture),
    .data_i  (evt_word),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .count_o (fifo_count)
  );

  assign bus.readdata = rdata_q;
  assign irq          = irq_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_sma_edge_capture.sv
// Directed and randomized bench for sma_edge_capture against a queue-based event model.
module tb_sma_edge_capture;
  import sma_pkg::*;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TSW   = 8;
  localparam int unsigned TSMASK = (1 << TSW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_port = 1'b0;
  logic irq;

  sma_edge_capture_if bus();

  sma_edge_capture #(
    .SYNC_STAGES (SYNC),
    .FIFO_DEPTH  (DEPTH),
    .TS_WIDTH    (TSW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release: the expected timestamp clock.
  int unsigned edges;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  logic [31:0] q[$];
  bit          m_ovf;
  logic [3:0]  m_ctrl;
  bit          m_pin;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = v;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  // The pin reaches the detector SYNC clocks after it changes; the stamp is that cycle's count.
  function automatic logic [31:0] ts_now();
    return (edges + SYNC) & TSMASK;
  endfunction

  function automatic void model_capture(input bit rising, input logic [31:0] ts);
    if (m_ctrl[0] && ((rising && m_ctrl[1]) || (!rising && m_ctrl[2]))) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back({rising, 31'(ts)});
    end
  endfunction

  task automatic set_pin(input bit v, input bit model);
    logic [31:0] ts;
    ts = ts_now();
    in_port = v;
    if (model && (v != m_pin)) model_capture(v, ts);
    m_pin = v;
  endtask

  function automatic logic [31:0] exp_status();
    return {23'd0, 5'(q.size()), 1'b0, m_ovf, (q.size() != 0), m_pin};
  endfunction

  task automatic status_check(input string tag);
    logic [31:0] d;
    bus_read(ADDR_STATUS, d);
    check(tag, d, exp_status());
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] d, e;
    bus_read(ADDR_EVENT, d);
    e = (q.size() != 0) ? q.pop_front() : 32'd0;
    check(tag, d, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, ts;
    int unsigned now_at, guard, n;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = '0; bus.writedata = '0;
    m_ovf = 1'b0; m_ctrl = '0; m_pin = 1'b0;

    idle(3);
    check("rst_rdata", bus.readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    bus_read(ADDR_NOW, d);
    check("now_start", d, 32'd0);
    status_check("rst_status");
    bus_read(ADDR_CONTROL, d);
    check("rst_control", d, 32'd0);

    // Single rising edge, held
    bus_write(ADDR_CONTROL, 32'h7); m_ctrl = 4'h7;
    set_pin(1'b1, 1'b1);
    idle(20);
    status_check("one_evt_status");
    pop_check("one_evt_event");
    status_check("one_evt_empty");
    now_at = edges;
    bus_read(ADDR_NOW, d);
    check("now_read", d, now_at & TSMASK);

    // Ten rising edges into an 8-deep FIFO
    bus_write(ADDR_CONTROL, 32'h3); m_ctrl = 4'h3;
    for (int i = 0; i < 10; i++) begin
      set_pin(1'b0, 1'b1); idle(2);
      set_pin(1'b1, 1'b1); idle(2);
    end
    idle(4);
    status_check("ovf_status");
    bus_write(ADDR_STATUS, 32'h4); m_ovf = 1'b0;
    status_check("ovf_cleared");

    // Full FIFO: push lands in the same cycle as an EVENT pop
    set_pin(1'b0, 1'b1); idle(4);
    ts = ts_now();
    set_pin(1'b1, 1'b0);
    idle(2);
    pop_check("coll_pop");
    q.push_back({1'b1, 31'(ts)});
    idle(3);
    status_check("coll_status");
    for (int i = 0; i < DEPTH; i++) pop_check("drain_pop");
    pop_check("drain_empty_pop");
    status_check("drain_status");

    // Interrupt rise and fall
    set_pin(1'b0, 1'b1); idle(4);
    bus_write(ADDR_CONTROL, 32'hF); m_ctrl = 4'hF;
    set_pin(1'b1, 1'b1);
    idle(3);
    check("irq_not_yet", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq_rise", {31'd0, irq}, 32'd1);
    pop_check("irq_pop");
    check("irq_hold", {31'd0, irq}, 32'd1);
    idle(1);
    check("irq_fall", {31'd0, irq}, 32'd0);

    // Flush with events queued
    set_pin(1'b0, 1'b1); idle(2);
    set_pin(1'b1, 1'b1); idle(4);
    status_check("preflush_status");
    bus_write(ADDR_CONTROL, 32'h1F); q.delete();
    status_check("flush_status");
    check("irq_after_flush", {31'd0, irq}, 32'd0);
    bus_read(ADDR_CONTROL, d);
    check("ctrl_readback", d, 32'hF);

    // Timestamp wrap at 2^TS_WIDTH
    bus_write(ADDR_CONTROL, 32'h3); m_ctrl = 4'h3;
    set_pin(1'b0, 1'b1); idle(4);
    bus_write(ADDR_CONTROL, 32'h7); m_ctrl = 4'h7;
    guard = 0;
    while (((edges & TSMASK) != 253) && (guard < 300)) begin
      idle(1); guard++;
    end
    check("wrap_reached", edges & TSMASK, 32'd253);
    set_pin(1'b1, 1'b1); idle(2);
    set_pin(1'b0, 1'b1); idle(4);
    check("wrap_model_a", q[0], 32'h8000_00FF);
    check("wrap_model_b", q[1], 32'h0000_0001);
    pop_check("wrap_first");
    pop_check("wrap_second");

    // Randomized edge bursts with random rise/fall enables
    for (int r = 0; r < 6; r++) begin
      m_ctrl = {1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
      bus_write(ADDR_CONTROL, {28'd0, m_ctrl});
      n = $urandom_range(4, 14);
      for (int k = 0; k < n; k++) begin
        set_pin(~m_pin, 1'b1);
        idle($urandom_range(1, 3));
      end
      idle(4);
      status_check("rand_status");
      while (q.size() != 0) pop_check("rand_pop");
      if (m_ovf) begin
        bus_write(ADDR_STATUS, 32'h4); m_ovf = 1'b0;
      end
    end

    // Reset with three events queued
    bus_write(ADDR_CONTROL, 32'hF); m_ctrl = 4'hF;
    for (int k = 0; k < 3; k++) begin
      set_pin(~m_pin, 1'b1); idle(2);
    end
    idle(4);
    status_check("prereset_status");
    check("prereset_irq", {31'd0, irq}, 32'd1);
    bus_read(ADDR_NOW, d);
    reset_n = 1'b0;
    #1;
    check("reset_rdata", bus.readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    q.delete(); m_ovf = 1'b0; m_ctrl = '0;
    idle(2);
    reset_n = 1'b1;
    bus_read(ADDR_NOW, d);
    check("reset_now", d, 32'd0);
    bus_read(ADDR_CONTROL, d);
    check("reset_control", d, 32'd0);
    status_check("reset_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
